// File: rtl/band_gain_scale.sv
// ============================================================================
// band_gain_scale
// ----------------------------------------------------------------------------
// Applies a per-band gain to the five equalizer band samples (LP, B1, B2,
// B3, HP). One shared 16x13 multiplier is stepped across the bands in five
// consecutive cycles. The saturated 16-bit results go to the five-way band
// summer downstream. A new sample set can be accepted every 6 clocks.
//
// Parameters
//   GAIN_W  unsigned gain width. 1 << (GAIN_W-1) is unity gain.
//   FRAC    product right-shift. Must equal GAIN_W-1.
//
// Ports
//   clk                     system clock, rising edge
//   rst_n                   asynchronous active-low reset
//   start                   scale the presented set (ignored while busy)
//   LP,B1,B2,B3,HP          signed 16-bit band samples
//   LP_gain..HP_gain        unsigned GAIN_W-bit band gains
//   LP_scl..HP_scl          registered, saturated scaled bands; all five
//                           update together on the valid edge
//   valid                   one-cycle pulse when the *_scl outputs update
//   busy                    high while a set is being processed
//
// Build option
//   BAND_SCALE_ROUND_EN     when defined, adds 2^(FRAC-1) before the shift
//                           (round half up). Otherwise the shift truncates
//                           toward -inf. Latency is the same in both builds.
// ============================================================================
module band_gain_scale #(
    parameter int GAIN_W = 12,
    parameter int FRAC   = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [15:0]       LP,
    input  logic signed [15:0]       B1,
    input  logic signed [15:0]       B2,
    input  logic signed [15:0]       B3,
    input  logic signed [15:0]       HP,
    input  logic        [GAIN_W-1:0] LP_gain,
    input  logic        [GAIN_W-1:0] B1_gain,
    input  logic        [GAIN_W-1:0] B2_gain,
    input  logic        [GAIN_W-1:0] B3_gain,
    input  logic        [GAIN_W-1:0] HP_gain,
    output logic signed [15:0]       LP_scl,
    output logic signed [15:0]       B1_scl,
    output logic signed [15:0]       B2_scl,
    output logic signed [15:0]       B3_scl,
    output logic signed [15:0]       HP_scl,
    output logic                     valid,
    output logic                     busy
);

    localparam int DATA_W = 16;
    localparam int NBANDS = 5;
    // Signed sample times the zero-extended gain.
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    // Width left once the fractional bits are dropped.
    localparam int SHR_W  = PROD_W - FRAC;

    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [PROD_W-1:0] RND_BIAS = PROD_W'(1 << (FRAC - 1));

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam logic [2:0] IDX_LAST = 3'd4;

    // ------------------------------------------------------------------------
    // Drop the FRAC fractional bits, with optional round-half-up.
    // Taking the upper bits of a signed word is an arithmetic shift.
    // The bias cannot overflow PROD_W: the largest product magnitude is below
    // 2^(PROD_W-2).
    // ------------------------------------------------------------------------
    function automatic logic signed [SHR_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] p
    );
        logic signed [PROD_W-1:0] biased;
`ifdef BAND_SCALE_ROUND_EN
        biased = p + RND_BIAS;
`else
        biased = p;
`endif
        return biased[PROD_W-1:FRAC];
    endfunction

    // ------------------------------------------------------------------------
    // Clamp to DATA_W bits.
    // The value fits only if every bit from the sign bit down to bit DATA_W-1
    // matches. If it does not fit, the sign selects the rail.
    // ------------------------------------------------------------------------
    function automatic logic signed [DATA_W-1:0] sat(
        input logic signed [SHR_W-1:0] v
    );
        logic [SHR_W-DATA_W:0] top;
        top = v[SHR_W-1:DATA_W-1];
        if (top != {(SHR_W-DATA_W+1){v[SHR_W-1]}})
            return v[SHR_W-1] ? SAT_MIN : SAT_MAX;
        else
            return v[DATA_W-1:0];
    endfunction

    logic [0:0] state;
    logic [2:0] idx;

    // Latched sample set; inputs may change freely after the start edge.
    logic signed [DATA_W-1:0] smp_p0  [NBANDS];
    logic        [GAIN_W-1:0] gain_p0 [NBANDS];
    // Working results for LP..B3; HP goes straight to its output.
    logic signed [DATA_W-1:0] res_p1  [NBANDS-1];

    logic signed [DATA_W-1:0] sel_smp;
    logic        [GAIN_W-1:0] sel_gain;
    logic signed [PROD_W-1:0] smp_x;
    logic signed [PROD_W-1:0] gain_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [DATA_W-1:0] sat_val;

    // ------------------------------------------------------------------------
    // Stage p0 -> p1: select the band, multiply, shift, saturate
    // ------------------------------------------------------------------------
    always_comb begin
        sel_smp  = smp_p0[0];
        sel_gain = gain_p0[0];
        case (idx)
            3'd0: begin sel_smp = smp_p0[0]; sel_gain = gain_p0[0]; end
            3'd1: begin sel_smp = smp_p0[1]; sel_gain = gain_p0[1]; end
            3'd2: begin sel_smp = smp_p0[2]; sel_gain = gain_p0[2]; end
            3'd3: begin sel_smp = smp_p0[3]; sel_gain = gain_p0[3]; end
            3'd4: begin sel_smp = smp_p0[4]; sel_gain = gain_p0[4]; end
            default: begin sel_smp = smp_p0[0]; sel_gain = gain_p0[0]; end
        endcase
    end

    // Widen both operands to the product width before multiplying.
    // The gain is unsigned, so it is zero-extended.
    assign smp_x   = {{(PROD_W-DATA_W){sel_smp[DATA_W-1]}}, sel_smp};
    assign gain_x  = {{(PROD_W-GAIN_W){1'b0}}, sel_gain};
    assign prod    = smp_x * gain_x;
    assign sat_val = sat(round_shift(prod));

    // ------------------------------------------------------------------------
    // Sequencer: latch the inputs, step idx over the bands, commit the outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= 3'd0;
            busy   <= 1'b0;
            valid  <= 1'b0;
            LP_scl <= '0;
            B1_scl <= '0;
            B2_scl <= '0;
            B3_scl <= '0;
            HP_scl <= '0;
            for (int i = 0; i < NBANDS; i++) begin
                smp_p0[i]  <= '0;
                gain_p0[i] <= '0;
            end
            for (int i = 0; i < NBANDS - 1; i++)
                res_p1[i] <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        smp_p0[0]  <= LP;
                        smp_p0[1]  <= B1;
                        smp_p0[2]  <= B2;
                        smp_p0[3]  <= B3;
                        smp_p0[4]  <= HP;
                        gain_p0[0] <= LP_gain;
                        gain_p0[1] <= B1_gain;
                        gain_p0[2] <= B2_gain;
                        gain_p0[3] <= B3_gain;
                        gain_p0[4] <= HP_gain;
                        idx        <= 3'd0;
                        busy       <= 1'b1;
                        state      <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (idx == IDX_LAST) begin
                        // All five outputs change together on this edge.
                        LP_scl <= res_p1[0];
                        B1_scl <= res_p1[1];
                        B2_scl <= res_p1[2];
                        B3_scl <= res_p1[3];
                        HP_scl <= sat_val;
                        valid  <= 1'b1;
                        busy   <= 1'b0;
                        idx    <= 3'd0;
                        state  <= S_IDLE;
                    end else if (idx < IDX_LAST) begin
                        res_p1[idx[1:0]] <= sat_val;
                        idx              <= idx + 3'd1;
                    end else begin
                        // idx should never exceed 4. If it does, drop the
                        // set and return to IDLE instead of stalling.
                        idx   <= 3'd0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: begin
                    idx   <= 3'd0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_gain_scale.sv
// ============================================================================
// tb_band_gain_scale
// ----------------------------------------------------------------------------
// Self-checking bench for band_gain_scale.
// Vectors are pushed to a scoreboard when the DUT accepts them. A negedge
// monitor pops one entry on each valid pulse and checks the five outputs and
// the start-to-valid latency. Between pulses it checks that the outputs hold
// their last committed values.
// ============================================================================
module tb_band_gain_scale;

    typedef struct {
        logic [4:0][15:0] s;   // index 0 = LP ... 4 = HP
        logic [4:0][11:0] g;
        logic [4:0][15:0] e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic [15:0] lp, b1, b2, b3, hp;
    logic [11:0] glp, gb1, gb2, gb3, ghp;
    logic [15:0] lp_scl, b1_scl, b2_scl, b3_scl, hp_scl;
    logic        valid, busy;
    logic [4:0][15:0] outs;

    assign outs = {hp_scl, b3_scl, b2_scl, b1_scl, lp_scl};

    band_gain_scale #(.GAIN_W(12), .FRAC(11)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .LP(lp), .B1(b1), .B2(b2), .B3(b3), .HP(hp),
        .LP_gain(glp), .B1_gain(gb1), .B2_gain(gb2), .B3_gain(gb3), .HP_gain(ghp),
        .LP_scl(lp_scl), .B1_scl(b1_scl), .B2_scl(b2_scl), .B3_scl(b3_scl),
        .HP_scl(hp_scl), .valid(valid), .busy(busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    logic mon_en = 1'b0;
    vec_t sb[$];
    int   acc_q[$];
    logic [4:0][15:0] held = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Integer reference: product, optional bias, floor shift, clamp.
    function automatic logic [15:0] ref_scale(input logic [15:0] s, input logic [11:0] g);
        longint p, q;
        p = longint'($signed(s)) * longint'(g);
`ifdef BAND_SCALE_ROUND_EN
        p = p + 1024;
`endif
        q = p >>> 11;
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    function automatic vec_t mk(input logic [4:0][15:0] s, input logic [4:0][11:0] g);
        vec_t v;
        v.s = s;
        v.g = g;
        for (int i = 0; i < 5; i++) v.e[i] = ref_scale(s[i], g[i]);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        logic [4:0][15:0] s;
        logic [4:0][11:0] g;
        for (int i = 0; i < 5; i++) begin
            s[i] = 16'($urandom);
            g[i] = 12'($urandom);
        end
        return mk(s, g);
    endfunction

    task automatic drive(input vec_t v);
        lp  = v.s[0]; b1  = v.s[1]; b2  = v.s[2]; b3  = v.s[3]; hp  = v.s[4];
        glp = v.g[0]; gb1 = v.g[1]; gb2 = v.g[2]; gb3 = v.g[3]; ghp = v.g[4];
    endtask

    // Call this #1 after a rising edge. busy at that moment is the value the
    // next edge will see, so it tells whether the request will be taken.
    task automatic start_set(input vec_t v);
        logic was_idle;
        drive(v);
        start    = 1'b1;
        was_idle = !busy;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (was_idle) begin
            sb.push_back(v);
            acc_q.push_back(cyc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk); #1; n++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            if (valid) begin
                chk("pending_set_at_valid", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    vec_t v;
                    int   a;
                    v = sb.pop_front();
                    a = acc_q.pop_front();
                    for (int i = 0; i < 5; i++)
                        chk($sformatf("band%0d_scl", i), 32'(outs[i]), 32'(v.e[i]));
                    chk("latency", 32'(cyc - a), 32'd5);
                    held = v.e;
                end
            end else begin
                for (int i = 0; i < 5; i++)
                    chk($sformatf("band%0d_hold", i), 32'(outs[i]), 32'(held[i]));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    vec_t tbl[10];
    vec_t va, vb, vc;

    initial begin
        // ---------------- vector table ----------------
        tbl[0] = mk({16'h8000, 16'h7FFF, 16'h0001, 16'hC000, 16'h4000}, {5{12'h800}});
        tbl[0].e = {16'h8000, 16'h7FFF, 16'h0001, 16'hC000, 16'h4000};
        tbl[1] = mk({16'hFFFF, 16'h0001, 16'h1234, 16'h8000, 16'h7FFF},
                    {12'h400, 12'h400, 12'h000, 12'hFFF, 12'hFFF});
`ifdef BAND_SCALE_ROUND_EN
        tbl[1].e = {16'h0000, 16'h0001, 16'h0000, 16'h8000, 16'h7FFF};
`else
        tbl[1].e = {16'hFFFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
`endif
        tbl[2] = mk({16'h8000, 16'h7FFF, 16'hFFFF, 16'h5A5A, 16'h1234}, {5{12'h000}});
        tbl[2].e = '0;
        tbl[3] = mk({16'hFFFF, 16'h0003, 16'hFFFD, 16'h2000, 16'hE000},
                    {12'h7FF, 12'h801, 12'hC00, 12'hFFF, 12'h001});
        for (int i = 4; i < 10; i++) tbl[i] = rnd_vec();

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        start = 1'b0;
        drive(tbl[2]);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) chk($sformatf("reset_band%0d", i), 32'(outs[i]), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // ---------------- table vectors, back-to-back ----------------
        for (int i = 0; i < 10; i++) begin
            wait_idle();
            start_set(tbl[i]);
            if (i == 0) chk("busy_after_start", 32'(busy), 32'd1);
        end
        wait_drain();

        // ---------------- ignored start, input change, start in valid cycle ----
        va = rnd_vec();
        vb = rnd_vec();
        vc = rnd_vec();
        wait_idle();
        start_set(va);                        // E0
        @(posedge clk); #1;                   // E1
        chk("busy_mid_set", 32'(busy), 32'd1);
        drive(vb);
        start = 1'b1;                         // sampled at E2; must be ignored
        @(posedge clk); #1;
        start = 1'b0;
        drive(rnd_vec());                     // inputs keep changing while busy
        begin
            int n = 0;
            while (!valid && n < 10) begin
                @(posedge clk); #1; n++;
            end
        end
        chk("valid_seen_for_first_set", 32'(valid), 32'd1);
        start_set(vc);                        // accepted in the valid cycle
        wait_drain();

        // ---------------- reset mid-operation ----------------
        wait_idle();
        start_set(tbl[3]);                    // E0
        repeat (3) @(posedge clk);            // E3
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) chk($sformatf("abort_band%0d", i), 32'(outs[i]), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(valid), 32'd0);
        sb.delete();
        acc_q.delete();
        held = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);           // any valid here is reported by the monitor
        #1;
        chk("idle_after_abort", 32'(busy), 32'd0);
        start_set(tbl[1]);
        wait_drain();

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
